// File: rtl/exp_accel_core.sv
`default_nettype none
// ============================================================================
//  Module      : exp_accel_core
//  Description : Integer exponentiation engine. Computes base^exp truncated to
//                DATA_W bits using LSB-first square-and-multiply, one exponent
//                bit per cycle, with a sticky overflow flag. Valid/ready
//                handshake on both the operand and the result channels.
//  Options     : SATURATE_EN - when defined, an overflowed result is replaced
//                by all-ones (out_ovf still reports the overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_accel_core #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_base,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [EXP_W-1:0]    e_q, e_d;
    logic                b_ovf_q, b_ovf_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                res_ovf_q, res_ovf_d;

    logic [2*DATA_W-1:0] prod_ab;
    logic [2*DATA_W-1:0] prod_bb;
    logic [DATA_W-1:0]   final_res;
    logic                accept;
    logic                finish;

    // Full-width products so the upper half can be inspected for overflow.
    assign prod_ab = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, b_q};
    assign prod_bb = {{DATA_W{1'b0}}, b_q} * {{DATA_W{1'b0}}, b_q};

    assign accept = (state_q == S_IDLE) && in_valid;
    assign finish = (state_q == S_RUN) && (e_q == '0);

`ifdef SATURATE_EN
    // Overflowed results clamp to the largest representable value.
    assign final_res = ovf_q ? {DATA_W{1'b1}} : acc_q;
`else
    // Overflowed results wrap; out_ovf tells the consumer.
    assign final_res = acc_q;
`endif

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN until the exponent is
    // exhausted, hold in DONE until the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (finish)    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_result = res_q;
    assign out_ovf    = res_ovf_q;

    // Datapath next state: load operands, one square-and-multiply step per
    // RUN cycle, then latch the result when the exponent reaches zero.
    always_comb begin
        acc_d     = acc_q;
        b_d       = b_q;
        e_d       = e_q;
        b_ovf_d   = b_ovf_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (accept) begin
            acc_d   = {{(DATA_W-1){1'b0}}, 1'b1};
            b_d     = in_base;
            e_d     = in_exp;
            b_ovf_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            if (e_q == '0) begin
                res_d     = final_res;
                res_ovf_d = ovf_q;
            end else begin
                // A pending b overflow only matters once b is folded into acc.
                if (e_q[0]) begin
                    acc_d = prod_ab[DATA_W-1:0];
                    if ((prod_ab[2*DATA_W-1:DATA_W] != '0) || b_ovf_q) begin
                        ovf_d = 1'b1;
                    end
                end
                b_d = prod_bb[DATA_W-1:0];
                if (prod_bb[2*DATA_W-1:DATA_W] != '0) begin
                    b_ovf_d = 1'b1;
                end
                e_d = e_q >> 1;
            end
        end
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_q     <= '0;
            b_q       <= '0;
            e_q       <= '0;
            b_ovf_q   <= 1'b0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            b_q       <= b_d;
            e_q       <= e_d;
            b_ovf_q   <= b_ovf_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_accel_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_accel_core
//  Description : Directed self-checking bench for exp_accel_core
//                (DATA_W=32, EXP_W=8). Honours SATURATE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_accel_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit sat;

    exp_accel_core #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_base       (in_base),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_ovf       (out_ovf),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full operation: present operands, scramble them after accept, measure
    // latency in rising edges from the accept edge, check result, consume it.
    task automatic run_op(input logic [31:0] base, input logic [7:0] ex,
                          input logic [31:0] exp_res, input logic exp_ovf,
                          input int exp_lat, input string name);
        int n;
        @(negedge clk);
        in_base  = base;
        in_exp   = ex;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        n = 1;
        #1;
        in_valid = 1'b0;
        in_base  = 32'hDEADBEEF;
        in_exp   = 8'hFF;
        while (n < 60) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (n !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        n_cmp++;
        if (out_result !== exp_res || out_ovf !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s result: got %h/%b want %h/%b", name, out_result, out_ovf, exp_res, exp_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s post-handshake: got valid=%b ready=%b busy=%b want 0/1/0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_base   = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_result !== 32'd0) begin n_bad++; $display("FAIL reset out_result: got %h want 0", out_result); end
        n_cmp++;
        if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset out_ovf: got %b want 0", out_ovf); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        run_op(32'd3, 8'd5, 32'd243, 1'b0, 5, "3^5");
        run_op(32'd7, 8'd0, 32'd1, 1'b0, 2, "7^0");
        run_op(32'd7, 8'd11, 32'd1977326743, 1'b0, 6, "7^11");
        run_op(32'd10, 8'd10, sat ? 32'hFFFFFFFF : 32'd1410065408, 1'b1, 6, "10^10");
    endtask

    task automatic test_boundary();
        run_op(32'd2, 8'd31, 32'h80000000, 1'b0, 7, "2^31");
        run_op(32'd2, 8'd32, sat ? 32'hFFFFFFFF : 32'h0, 1'b1, 8, "2^32");
        run_op(32'd1, 8'd255, 32'd1, 1'b0, 10, "1^255");
        run_op(32'd0, 8'd0, 32'd1, 1'b0, 2, "0^0");
        run_op(32'd0, 8'd5, 32'd0, 1'b0, 5, "0^5");
    endtask

    task automatic test_backpressure();
        int n;
        int bad_cycles;
        @(negedge clk);
        in_base  = 32'd3;
        in_exp   = 8'd4;
        in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        in_valid = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 5 || out_result !== 32'd81 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL bp first: got lat=%0d res=%0d ovf=%b want 5/81/0", n, out_result, out_ovf);
        end
        // Hold the result for 20 cycles while offering a new operand.
        in_base    = 32'd5;
        in_exp     = 8'd3;
        in_valid   = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== 32'd81 || out_ovf !== 1'b0 || in_ready !== 1'b0)
                bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL bp hold: got %0d unstable cycles want 0", bad_cycles);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        n = 1;
        #1;
        in_valid = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 4 || out_result !== 32'd125 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL bp pending: got lat=%0d res=%0d ovf=%b want 4/125/0", n, out_result, out_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int seen;
        int t0;
        int t1;
        int t2;
        int bad_res;
        @(negedge clk);
        in_base   = 32'd2;
        in_exp    = 8'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0; seen = 0; t0 = 0; t1 = 0; t2 = 0; bad_res = 0;
        while (seen < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                if (out_result !== 32'd8 || out_ovf !== 1'b0) bad_res++;
                if (seen == 0) t0 = cyc;
                else if (seen == 1) t1 = cyc;
                else t2 = cyc;
                seen++;
            end
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (seen !== 3 || bad_res !== 0) begin
            n_bad++;
            $display("FAIL b2b results: got %0d seen, %0d bad want 3, 0", seen, bad_res);
        end
        n_cmp++;
        if ((t1 - t0) !== 5 || (t2 - t1) !== 5) begin
            n_bad++;
            $display("FAIL b2b spacing: got %0d,%0d want 5,5", t1 - t0, t2 - t1);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b drain: got ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        in_base  = 32'd3;
        in_exp   = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_result !== 32'd0 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL abort outputs: got busy=%b ready=%b valid=%b res=%h ovf=%b want 0/1/0/0/0",
                     busy, in_ready, out_valid, out_result, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd5, 8'd3, 32'd125, 1'b0, 4, "after-abort 5^3");
    endtask

    initial begin
`ifdef SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard ceiling in case the design wedges somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
